// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demultiplexer with frame alignment checking
// Slot 0 is marked by sof; each accepted sample lands in its channel register one cycle later.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       d0,
  input  logic               v0,
  input  logic               sof,
  output logic [NCH*W-1:0]   z0,
  output logic [NCH-1:0]     zv,
  output logic               frame_done,
  output logic               err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCH*W-1:0]   z_q, z_d;
  logic [NCH-1:0]     zv_q, zv_d;
  logic               fd_q, fd_d;
  logic               err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= '0;
      zv_q    <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    zv_d    = '0;
    fd_d    = 1'b0;
    err_d   = 1'b0;

    if (v0) begin
      unique case (state_q)
        IDLE: begin
          if (sof) begin
            z_d[0 +: W] = d0;
            zv_d[0]     = 1'b1;
            if (NCH == 1) begin
              fd_d = 1'b1;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = RUN;
            end
          end else begin
            // Orphan sample: nothing to align it to, so drop it.
            err_d = 1'b1;
          end
        end

        RUN: begin
          if (sof) begin
            // Short frame: abandon it and restart alignment on this sample.
            err_d       = 1'b1;
            z_d[0 +: W] = d0;
            zv_d[0]     = 1'b1;
            cnt_d       = CNT_ONE;
          end else begin
            z_d[int'(cnt_q)*W +: W] = d0;
            zv_d[cnt_q]             = 1'b1;
            if (cnt_q == CNT_LAST) begin
              fd_d    = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign z0         = z_q;
  assign zv         = zv_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux with NCH=4, W=8
module tb_tdm_demux;

  logic        clk;
  logic        rst;
  logic [7:0]  d0;
  logic        v0;
  logic        sof;
  logic [31:0] z0;
  logic [3:0]  zv;
  logic        frame_done;
  logic        err;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int          due;
    logic [3:0]  zv;
    logic        fd;
    logic        er;
    logic [31:0] z;
  } exp_t;

  exp_t sb[$];

  tdm_demux #(.NCH(4), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .d0         (d0),
    .v0         (v0),
    .sof        (sof),
    .z0         (z0),
    .zv         (zv),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every registered output cycle is matched against the entry due for it.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks = checks + 1;
      if (e.due != cyc || zv !== e.zv || frame_done !== e.fd || err !== e.er || z0 !== e.z) begin
        errors = errors + 1;
        $display("FAIL out_cyc%0d: got zv=%b frame_done=%b err=%b z0=%h, expected zv=%b frame_done=%b err=%b z0=%h (due %0d)",
                 cyc, zv, frame_done, err, z0, e.zv, e.fd, e.er, e.z, e.due);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d,
                      input logic [3:0] ezv, input logic efd, input logic eerr,
                      input logic [31:0] ez);
    exp_t e;
    rst = r;
    v0  = v;
    sof = s;
    d0  = d;
    e.due = cyc + 1;
    e.zv  = ezv;
    e.fd  = efd;
    e.er  = eerr;
    e.z   = ez;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; v0 = 1'b1; sof = 1'b1; d0 = 8'hFF;

    // Reset held with an active sof sample on the inputs
    step(1, 1, 1, 8'hFF, 4'b0000, 0, 0, 32'h00000000);
    step(1, 1, 1, 8'hFF, 4'b0000, 0, 0, 32'h00000000);

    // Nominal back-to-back frame
    step(0, 1, 1, 8'h11, 4'b0001, 0, 0, 32'h00000011);
    step(0, 1, 0, 8'h22, 4'b0010, 0, 0, 32'h00002211);
    step(0, 1, 0, 8'h33, 4'b0100, 0, 0, 32'h00332211);
    step(0, 1, 0, 8'h44, 4'b1000, 1, 0, 32'h44332211);

    // Gapped frame; idle cycles carry junk data and an unqualified sof
    step(0, 1, 1, 8'h55, 4'b0001, 0, 0, 32'h44332255);
    step(0, 0, 1, 8'hEE, 4'b0000, 0, 0, 32'h44332255);
    step(0, 1, 0, 8'h66, 4'b0010, 0, 0, 32'h44336655);
    step(0, 0, 0, 8'h99, 4'b0000, 0, 0, 32'h44336655);
    step(0, 0, 1, 8'h99, 4'b0000, 0, 0, 32'h44336655);
    step(0, 1, 0, 8'h77, 4'b0100, 0, 0, 32'h44776655);
    step(0, 0, 0, 8'h12, 4'b0000, 0, 0, 32'h44776655);
    step(0, 1, 0, 8'h88, 4'b1000, 1, 0, 32'h88776655);

    // Short frame resynchronised by a second sof
    step(0, 1, 1, 8'hAA, 4'b0001, 0, 0, 32'h887766AA);
    step(0, 1, 0, 8'hBB, 4'b0010, 0, 0, 32'h8877BBAA);
    step(0, 1, 1, 8'hCC, 4'b0001, 0, 1, 32'h8877BBCC);
    step(0, 1, 0, 8'hDD, 4'b0010, 0, 0, 32'h8877DDCC);
    step(0, 1, 0, 8'hEE, 4'b0100, 0, 0, 32'h88EEDDCC);
    step(0, 1, 0, 8'hFF, 4'b1000, 1, 0, 32'hFFEEDDCC);

    // Orphan sample in IDLE, then a frame start lands in channel 0
    step(0, 1, 0, 8'h5A, 4'b0000, 0, 1, 32'hFFEEDDCC);
    step(0, 1, 1, 8'h12, 4'b0001, 0, 0, 32'hFFEEDD12);
    step(0, 1, 0, 8'h34, 4'b0010, 0, 0, 32'hFFEE3412);

    // Reset mid-frame, then a clean full frame
    step(1, 1, 0, 8'h77, 4'b0000, 0, 0, 32'h00000000);
    step(0, 1, 1, 8'h01, 4'b0001, 0, 0, 32'h00000001);
    step(0, 1, 0, 8'h02, 4'b0010, 0, 0, 32'h00000201);
    step(0, 1, 0, 8'h03, 4'b0100, 0, 0, 32'h00030201);
    step(0, 1, 0, 8'h04, 4'b1000, 1, 0, 32'h04030201);

    // Trailing data without sof after a completed frame is an orphan
    step(0, 1, 0, 8'h42, 4'b0000, 0, 1, 32'h04030201);
    step(0, 0, 0, 8'h00, 4'b0000, 0, 0, 32'h04030201);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected outputs never observed, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
